// File: rtl/seq_booth_multiplier.sv
// Radix-2 Booth sequential multiplier with a WIDTH parameter and signed/unsigned selection
// for each operation. Operands enter and results leave through valid/ready handshakes.
// When ZERO_SKIP is set, an operation with a zero operand finishes without running the Booth steps.
module seq_booth_multiplier #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  // The accumulator carries one guard bit beyond the (WIDTH+1)-bit extended operands.
  // An add or subtract of the multiplicand can reach nearly 2^(WIDTH+1) in magnitude
  // before the shift. The low 2*WIDTH bits of {acc,q} are still the exact product.
  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_acc;
  logic [AW-1:0]       r_mcand;
  logic [QW-1:0]       r_q;
  logic                r_qm1;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_prod;
  logic                r_out_valid;
  logic                r_busy;

  logic                w_accept;
  logic                w_zero;
  logic [AW-1:0]       w_a_ext;
  logic [QW-1:0]       w_b_ext;
  logic [AW-1:0]       w_sum;
  logic [AW+QW-1:0]    w_shift;

  // Operand acceptance and extension of each operand to the internal width
  always_comb begin
    in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    w_accept = in_valid & in_ready;
    w_zero   = ZERO_SKIP && ((a == '0) || (b == '0));
    w_a_ext  = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    w_b_ext  = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
  end

  // One Booth step: conditional add/subtract, then arithmetic right shift of {acc,q}
  always_comb begin
    w_sum = r_acc;
    if (r_q[0] && !r_qm1)
      w_sum = r_acc - r_mcand;
    else if (!r_q[0] && r_qm1)
      w_sum = r_acc + r_mcand;
    w_shift = $signed({w_sum, r_q}) >>> 1;
  end

  // Control FSM and datapath registers; outputs are registered alongside the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_mcand <= w_a_ext;
      r_q     <= w_b_ext;
      r_qm1   <= 1'b0;
      r_acc   <= '0;
      if (w_zero) begin
        r_prod      <= '0;
        r_cnt       <= '0;
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        r_cnt       <= CNT_LOAD;
        r_state     <= S_RUN;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b1;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= w_shift[AW+QW-1:QW];
          r_q   <= w_shift[QW-1:0];
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_prod      <= w_shift[2*WIDTH-1:0];
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        S_IDLE: ;
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign prod      = r_prod;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Testbench for seq_booth_multiplier.
// Instance u_dut32 uses WIDTH=32 with zero skip enabled.
// Instance u_dut8 uses WIDTH=8 with zero skip disabled.
// Expected products are computed with plain integer arithmetic.
module tb_seq_booth_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;

  logic        iv32, ir32, sg32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  logic        iv8, ir8, sg8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_errors = 0;

  seq_booth_multiplier #(.WIDTH(32), .ZERO_SKIP(1'b1)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32), .is_signed(sg32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .prod(p32), .busy(busy32)
  );

  seq_booth_multiplier #(.WIDTH(8), .ZERO_SKIP(1'b0)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .is_signed(sg8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .prod(p8), .busy(busy8)
  );

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int sx, sy, p;
    if (s) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'(x);
      sy = int'(y);
    end
    p = sx * sy;
    return p[15:0];
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Run one operation on the 32-bit instance. Call at posedge+1 while in_ready is high.
  // lat is the number of clock edges from the accept edge until out_valid is seen.
  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output int lat, output logic busy_after);
    iv32 = 1'b1; a32 = x; b32 = y; sg32 = s;
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = 1'($urandom_range(0, 1));
    busy_after = busy32;
    lat = 0;
    while (ov32 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s, output int lat);
    iv8 = 1'b1; a8 = x; b8 = y; sg8 = s;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom_range(0, 1));
    lat = 0;
    while (ov8 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire32();
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic retire8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    iv32 = 0; or32 = 0; sg32 = 0; a32 = '0; b32 = '0;
    iv8 = 0; or8 = 0; sg8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, busy32, ir32, p32} !== {1'b0, 1'b0, 1'b1, 64'h0})
      $display("FAIL reset32: got ov=%b busy=%b ir=%b prod=%h expected 0 0 1 0", ov32, busy32, ir32, p32);
    n_checks++;
    if ({ov8, busy8, ir8, p8} !== {1'b0, 1'b0, 1'b1, 16'h0})
      $display("FAIL reset8: got ov=%b busy=%b ir=%b prod=%h expected 0 0 1 0", ov8, busy8, ir8, p8);
    if ({ov32, busy32, ir32, p32} !== {1'b0, 1'b0, 1'b1, 64'h0}) n_errors++;
    if ({ov8, busy8, ir8, p8} !== {1'b0, 1'b0, 1'b1, 16'h0}) n_errors++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_signed_small();
    int lat;
    logic bz;
    run32(32'd5, 32'hFFFF_FFF9, 1'b1, lat, bz);
    n_checks++;
    if (bz !== 1'b1) begin n_errors++; $display("FAIL t1_busy: got %b expected 1", bz); end
    n_checks++;
    if (lat !== 33) begin n_errors++; $display("FAIL t1_latency: got %0d expected 33", lat); end
    n_checks++;
    if (p32 !== 64'hFFFF_FFFF_FFFF_FFDD) begin n_errors++; $display("FAIL t1_prod: got %h expected %h", p32, 64'hFFFF_FFFF_FFFF_FFDD); end
    retire32();
    n_checks++;
    if ({ov32, ir32, busy32} !== 3'b010 || p32 !== 64'hFFFF_FFFF_FFFF_FFDD) begin
      n_errors++;
      $display("FAIL t1_idle: got ov=%b ir=%b busy=%b prod=%h expected 0 1 0 %h", ov32, ir32, busy32, p32, 64'hFFFF_FFFF_FFFF_FFDD);
    end
  endtask

  task automatic test_all_ones();
    int lat;
    logic bz;
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bz);
    n_checks++;
    if (p32 !== 64'hFFFF_FFFE_0000_0001 || lat !== 33) begin n_errors++; $display("FAIL t2_unsigned: got %h lat %0d expected %h lat 33", p32, lat, 64'hFFFF_FFFE_0000_0001); end
    retire32();
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, bz);
    n_checks++;
    if (p32 !== 64'h1 || lat !== 33) begin n_errors++; $display("FAIL t2_signed: got %h lat %0d expected 1 lat 33", p32, lat); end
    retire32();
  endtask

  task automatic test_signed_min();
    int lat;
    logic bz;
    run32(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bz);
    n_checks++;
    if (p32 !== 64'h4000_0000_0000_0000) begin n_errors++; $display("FAIL t3_min32: got %h expected %h", p32, 64'h4000_0000_0000_0000); end
    retire32();
    run8(8'h80, 8'h80, 1'b1, lat);
    n_checks++;
    if (p8 !== 16'd16384) begin n_errors++; $display("FAIL t3_min8: got %h expected %h", p8, 16'd16384); end
    n_checks++;
    if (lat !== 9) begin n_errors++; $display("FAIL t3_latency8: got %0d expected 9", lat); end
    retire8();
  endtask

  task automatic test_zero_skip();
    int lat;
    logic bz;
    run32(32'd11, 32'd0, 1'b1, lat, bz);
    n_checks++;
    if (p32 !== 64'h0 || lat !== 0 || bz !== 1'b0) begin n_errors++; $display("FAIL t4_skip32: got %h lat %0d busy %b expected 0 lat 0 busy 0", p32, lat, bz); end
    retire32();
    run8(8'd11, 8'd0, 1'b0, lat);
    n_checks++;
    if (p8 !== 16'h0 || lat !== 9) begin n_errors++; $display("FAIL t4_noskip8: got %h lat %0d expected 0 lat 9", p8, lat); end
    retire8();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bz;
    run32(32'd3, 32'd4, 1'b0, lat, bz);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (p32 !== 64'd12 || ov32 !== 1'b1 || ir32 !== 1'b0) begin
        n_errors++;
        $display("FAIL t5_hold: got prod=%h ov=%b ir=%b expected c 1 0", p32, ov32, ir32);
      end
    end
    or32 = 1'b1; iv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFF9; sg32 = 1'b1;
    #1;
    n_checks++;
    if (ir32 !== 1'b1) begin n_errors++; $display("FAIL t5_ready: got %b expected 1", ir32); end
    @(posedge clk); #1;
    or32 = 1'b0; iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
    n_checks++;
    if (ov32 !== 1'b0 || busy32 !== 1'b1) begin n_errors++; $display("FAIL t5_nobubble: got ov=%b busy=%b expected 0 1", ov32, busy32); end
    lat = 0;
    while (ov32 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (p32 !== 64'd7 || lat !== 33) begin n_errors++; $display("FAIL t5_prod: got %h lat %0d expected 7 lat 33", p32, lat); end
    retire32();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    iv32 = 1'b1; a32 = 32'd123456; b32 = 32'd789; sg32 = 1'b0;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ov32, busy32, ir32, p32} !== {1'b0, 1'b0, 1'b1, 64'h0}) begin
      n_errors++;
      $display("FAIL t6_abort: got ov=%b busy=%b ir=%b prod=%h expected 0 0 1 0", ov32, busy32, ir32, p32);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32 !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_errors++; $display("FAIL t6_no_valid: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_operand_change();
    int lat;
    iv32 = 1'b1; a32 = 32'd12; b32 = 32'hFFFF_FFFC; sg32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'd2; b32 = 32'd3; sg32 = 1'b0;
    lat = 0;
    while (ov32 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (p32 !== 64'hFFFF_FFFF_FFFF_FFD0 || lat !== 33) begin n_errors++; $display("FAIL t6_change: got %h lat %0d expected %h lat 33", p32, lat, 64'hFFFF_FFFF_FFFF_FFD0); end
    iv32 = 1'b0;
    retire32();
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic bz, s;
    logic [31:0] x, y;
    logic [63:0] e;
    logic [7:0] x8, y8;
    logic [15:0] e8;
    for (int i = 0; i < 30; i++) begin
      x = pick32(); y = pick32(); s = 1'($urandom_range(0, 1));
      e = ref32(x, y, s);
      exp_lat = (x == 0 || y == 0) ? 0 : 33;
      run32(x, y, s, lat, bz);
      n_checks++;
      if (p32 !== e || lat !== exp_lat) begin
        n_errors++;
        $display("FAIL rand32: %h*%h s=%b got %h lat %0d expected %h lat %0d", x, y, s, p32, lat, e, exp_lat);
      end
      retire32();
    end
    for (int i = 0; i < 30; i++) begin
      x8 = 8'($urandom); y8 = 8'($urandom); s = 1'($urandom_range(0, 1));
      e8 = ref8(x8, y8, s);
      run8(x8, y8, s, lat);
      n_checks++;
      if (p8 !== e8 || lat !== 9) begin
        n_errors++;
        $display("FAIL rand8: %h*%h s=%b got %h lat %0d expected %h lat 9", x8, y8, s, p8, lat, e8);
      end
      retire8();
    end
  endtask

  initial begin
    test_reset();
    test_signed_small();
    test_all_ones();
    test_signed_min();
    test_zero_skip();
    test_back_to_back();
    test_reset_mid_run();
    test_operand_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
